// File: rtl/warships_link_if.sv
// Bundle of local request/answer handshakes and the peer link wires for one warships_link end.
// Link side uses a 4-phase req/ack pair; data is stable whenever the strobe is high.
interface warships_link_if #(
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4
);
    localparam int CW = X_ADDR_WIDTH + Y_ADDR_WIDTH;

    // valid/ready: a shot transfers on the rising clk edge where shot_valid && shot_ready;
    // answer_valid is taken only while a received shot awaits its answer; all *_valid outputs are 1-cycle pulses.
    logic          shot_valid;
    logic [CW-1:0] shot_cords;
    logic          shot_ready;
    logic          result_valid;
    logic          result_hit;
    logic          result_timeout;
    logic          rx_valid;
    logic [CW-1:0] rx_cords;
    logic          answer_valid;
    logic          answer_hit;

    logic          req_out;
    logic [CW-1:0] cords_out;
    logic          ack_in;
    logic          hit_in;
    logic          req_in;
    logic [CW-1:0] cords_in;
    logic          ack_out;
    logic          hit_out;

    logic [1:0]    tx_state;
    logic [1:0]    rx_state;

    modport slave (
        input  shot_valid, shot_cords, answer_valid, answer_hit,
        input  ack_in, hit_in, req_in, cords_in,
        output shot_ready, result_valid, result_hit, result_timeout,
        output rx_valid, rx_cords, req_out, cords_out, ack_out, hit_out,
        output tx_state, rx_state
    );

    modport master (
        output shot_valid, shot_cords, answer_valid, answer_hit,
        output ack_in, hit_in, req_in, cords_in,
        input  shot_ready, result_valid, result_hit, result_timeout,
        input  rx_valid, rx_cords, req_out, cords_out, ack_out, hit_out,
        input  tx_state, rx_state
    );
endinterface

// File: rtl/warships_link.sv
// Two independent 4-phase handshake engines (shot TX, shot RX) for a warships peer link.
// Optional feature: define LINK_TIMEOUT_EN to abandon a TX request after TIMEOUT_CYCLES.
module warships_link #(
    parameter int X_ADDR_WIDTH   = 4,
    parameter int Y_ADDR_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    warships_link_if.slave  bus
);
    localparam int CW = X_ADDR_WIDTH + Y_ADDR_WIDTH;

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_DROP = 2'd2} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_WAIT_ANS = 2'd1, RX_ACK = 2'd2} rx_state_e;

    tx_state_e     tx_state_q;
    rx_state_e     rx_state_q;

    logic          ack_meta_q, ack_sync_q;
    logic          req_meta_q, req_sync_q;

    logic          req_out_q;
    logic [CW-1:0] cords_out_q;
    logic          result_valid_q;
    logic          result_hit_q;

    logic          rx_valid_q;
    logic [CW-1:0] rx_cords_q;
    logic          ack_out_q;
    logic          hit_out_q;

`ifdef LINK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] to_cnt_q;
    logic             result_timeout_q;
`endif

    // Peer strobes come from another clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            req_meta_q <= 1'b0;
            req_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= bus.ack_in;
            ack_sync_q <= ack_meta_q;
            req_meta_q <= bus.req_in;
            req_sync_q <= req_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q     <= TX_IDLE;
            req_out_q      <= 1'b0;
            cords_out_q    <= '0;
            result_valid_q <= 1'b0;
            result_hit_q   <= 1'b0;
`ifdef LINK_TIMEOUT_EN
            to_cnt_q         <= '0;
            result_timeout_q <= 1'b0;
`endif
        end else begin
            result_valid_q <= 1'b0;
`ifdef LINK_TIMEOUT_EN
            result_timeout_q <= 1'b0;
`endif
            case (tx_state_q)
                TX_IDLE: begin
                    if (bus.shot_valid) begin
                        cords_out_q <= bus.shot_cords;
                        req_out_q   <= 1'b1;
                        tx_state_q  <= TX_REQ;
`ifdef LINK_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                    end
                end
                TX_REQ: begin
                    if (ack_sync_q) begin
                        result_hit_q   <= bus.hit_in;
                        result_valid_q <= 1'b1;
                        req_out_q      <= 1'b0;
                        tx_state_q     <= TX_DROP;
                    end
`ifdef LINK_TIMEOUT_EN
                    else if (to_cnt_q == CNT_LAST) begin
                        req_out_q        <= 1'b0;
                        result_timeout_q <= 1'b1;
                        tx_state_q       <= TX_DROP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                TX_DROP: begin
                    // A late ack after a timeout must still fall before the next shot.
                    if (!ack_sync_q) begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_valid_q <= 1'b0;
            rx_cords_q <= '0;
            ack_out_q  <= 1'b0;
            hit_out_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (req_sync_q) begin
                        rx_cords_q <= bus.cords_in;
                        rx_valid_q <= 1'b1;
                        rx_state_q <= RX_WAIT_ANS;
                    end
                end
                RX_WAIT_ANS: begin
                    if (bus.answer_valid) begin
                        hit_out_q  <= bus.answer_hit;
                        ack_out_q  <= 1'b1;
                        rx_state_q <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!req_sync_q) begin
                        ack_out_q  <= 1'b0;
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign bus.shot_ready   = (tx_state_q == TX_IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.result_hit   = result_hit_q;
    assign bus.req_out      = req_out_q;
    assign bus.cords_out    = cords_out_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_cords     = rx_cords_q;
    assign bus.ack_out      = ack_out_q;
    assign bus.hit_out      = hit_out_q;
    assign bus.tx_state     = tx_state_q;
    assign bus.rx_state     = rx_state_q;
`ifdef LINK_TIMEOUT_EN
    assign bus.result_timeout = result_timeout_q;
`else
    assign bus.result_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_warships_link.sv
// Loopback bench: two warships_link ends cross-wired, checked against an event-queue model.
module tb_warships_link;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int CW = XW + YW;
    localparam int TO = 16;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    warships_link_if #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW)) a_if ();
    warships_link_if #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW)) b_if ();

    warships_link #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW), .TIMEOUT_CYCLES(TO)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );
    warships_link #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW), .TIMEOUT_CYCLES(TO)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    assign b_if.req_in   = a_if.req_out;
    assign b_if.cords_in = a_if.cords_out;
    assign a_if.ack_in   = b_if.ack_out;
    assign a_if.hit_in   = b_if.hit_out;
    assign a_if.req_in   = b_if.req_out;
    assign a_if.cords_in = b_if.cords_out;
    assign b_if.ack_in   = a_if.ack_out;
    assign b_if.hit_in   = a_if.hit_out;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: every accepted shot must surface once at the peer; every accepted answer once at the shooter.
    logic [CW-1:0] a_rx_q[$];
    logic [CW-1:0] b_rx_q[$];
    logic [0:0]    a_res_q[$];
    logic [0:0]    b_res_q[$];
    int            a_to_q[$];
    int            a_t_ack = 0, b_t_ack = 0;
    logic          a_ack_prev = 1'b0, b_ack_prev = 1'b0;
    logic          a_ack_seen = 1'b0;
    logic [CW-1:0] e_c;
    logic [0:0]    e_h;
    logic          e_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        if (a_if.ack_in && !a_ack_prev) a_t_ack = cyc;
        if (b_if.ack_in && !b_ack_prev) b_t_ack = cyc;
        a_ack_prev = a_if.ack_in;
        b_ack_prev = b_if.ack_in;
        if (!rst) begin
            if (a_if.rx_valid) begin
                if (a_rx_q.size() == 0) chk("a_rx_unexpected", 1, 0);
                else begin e_c = a_rx_q.pop_front(); chk("a_rx_cords", a_if.rx_cords, e_c); end
            end
            if (b_if.rx_valid) begin
                if (b_rx_q.size() == 0) chk("b_rx_unexpected", 1, 0);
                else begin e_c = b_rx_q.pop_front(); chk("b_rx_cords", b_if.rx_cords, e_c); end
            end
            if (a_if.result_valid) begin
                chk("a_ack_to_result_latency", cyc - a_t_ack, 3);
                if (a_res_q.size() == 0) chk("a_result_unexpected", 1, 0);
                else begin e_h = a_res_q.pop_front(); chk("a_result_hit", a_if.result_hit, e_h); end
            end
            if (b_if.result_valid) begin
                chk("b_ack_to_result_latency", cyc - b_t_ack, 3);
                if (b_res_q.size() == 0) chk("b_result_unexpected", 1, 0);
                else begin e_h = b_res_q.pop_front(); chk("b_result_hit", b_if.result_hit, e_h); end
            end
            e_to = (a_to_q.size() > 0) && (a_to_q[0] == cyc);
            chk("a_result_timeout", a_if.result_timeout, e_to);
            if (e_to) void'(a_to_q.pop_front());
            chk("b_result_timeout", b_if.result_timeout, 0);
            if (a_if.ack_out) a_ack_seen = 1'b1;
        end
    end

    // Driver tasks
    task automatic fire(input bit side, input logic [CW-1:0] c, input bit hold);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((side == 0) ? !a_if.shot_ready : !b_if.shot_ready) && n < 60);
        chk("fire_ready_wait", (n < 60), 1);
        if (side == 0) begin a_if.shot_valid = 1'b1; a_if.shot_cords = c; end
        else           begin b_if.shot_valid = 1'b1; b_if.shot_cords = c; end
        @(posedge clk);
        #1;
        if (side == 0) begin
            b_rx_q.push_back(c);
            chk("a_req_out_1cyc", a_if.req_out, 1);
            chk("a_ready_low_busy", a_if.shot_ready, 0);
            if (!hold) a_if.shot_valid = 1'b0;
        end else begin
            a_rx_q.push_back(c);
            chk("b_req_out_1cyc", b_if.req_out, 1);
            chk("b_ready_low_busy", b_if.shot_ready, 0);
            if (!hold) b_if.shot_valid = 1'b0;
        end
    endtask

    task automatic wait_rx(input bit side);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((side == 0) ? !a_if.rx_valid : !b_if.rx_valid) && n < 60);
        chk(side ? "b_wait_rx" : "a_wait_rx", (n < 60), 1);
    endtask

    task automatic wait_res(input bit side);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((side == 0) ? !a_if.result_valid : !b_if.result_valid) && n < 60);
        chk(side ? "b_wait_result" : "a_wait_result", (n < 60), 1);
    endtask

    task automatic answer(input bit side, input logic hit, input bit expect_res);
        if (side == 0) begin
            a_if.answer_valid = 1'b1; a_if.answer_hit = hit;
            if (expect_res) b_res_q.push_back(hit);
        end else begin
            b_if.answer_valid = 1'b1; b_if.answer_hit = hit;
            if (expect_res) a_res_q.push_back(hit);
        end
        @(posedge clk);
        #1;
        a_if.answer_valid = 1'b0;
        b_if.answer_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_if.shot_ready && b_if.shot_ready && !a_if.req_out && !b_if.req_out &&
                     !a_if.ack_out && !b_if.ack_out) && n < 80);
        chk("wait_idle", (n < 80), 1);
        chk("a_rx_drained", a_rx_q.size(), 0);
        chk("b_rx_drained", b_rx_q.size(), 0);
        chk("a_res_drained", a_res_q.size(), 0);
        chk("b_res_drained", b_res_q.size(), 0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst = 1'b1;
        a_if.shot_valid = 1'b0; a_if.shot_cords = '0; a_if.answer_valid = 1'b0; a_if.answer_hit = 1'b0;
        b_if.shot_valid = 1'b0; b_if.shot_cords = '0; b_if.answer_valid = 1'b0; b_if.answer_hit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_shot_ready", a_if.shot_ready, 1);
        chk("rst_b_shot_ready", b_if.shot_ready, 1);
        chk("rst_a_req_out", a_if.req_out, 0);
        chk("rst_b_ack_out", b_if.ack_out, 0);
        chk("rst_b_hit_out", b_if.hit_out, 0);
        chk("rst_a_cords_out", a_if.cords_out, 0);
        chk("rst_b_rx_cords", b_if.rx_cords, 0);
        chk("rst_a_result_hit", a_if.result_hit, 0);

        // Single shot A -> B, answered hit
        fire(0, 8'h37, 0);
        wait_rx(1);
        chk("t1_b_rx_cords", b_if.rx_cords, 8'h37);
        answer(1, 1'b1, 1);
        wait_res(0);
        chk("t1_a_result_hit", a_if.result_hit, 1);
        wait_idle();
        chk("t1_a_cords_out_held", a_if.cords_out, 8'h37);

        // Both ends fire in the same cycle
        fork
            fire(0, 8'h00, 0);
            fire(1, 8'hBB, 0);
        join
        fork
            begin wait_rx(1); answer(1, 1'b1, 1); end
            begin wait_rx(0); answer(0, 1'b0, 1); end
        join
        fork
            wait_res(0);
            wait_res(1);
        join
        wait_idle();
        chk("t2_a_rx_cords", a_if.rx_cords, 8'hBB);
        chk("t2_b_rx_cords", b_if.rx_cords, 8'h00);
        chk("t2_a_result_hit", a_if.result_hit, 1);
        chk("t2_b_result_hit", b_if.result_hit, 0);

`ifdef LINK_TIMEOUT_EN
        // Peer never answers: request is abandoned TO cycles after req_out rises
        fire(0, 8'hC3, 0);
        a_to_q.push_back(cyc + TO);
        begin
            int n = 0;
            while (a_to_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
            chk("t3_timeout_seen", (n < 60), 1);
        end
        chk("t3_req_out_dropped", a_if.req_out, 0);
        chk("t3_result_hit_kept", a_if.result_hit, 1);
        answer(1, 1'b0, 0);
        wait_idle();
`endif

        // Reset in the middle of a transfer
        fire(0, 8'h66, 0);
        wait_rx(1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t4_a_req_out", a_if.req_out, 0);
        chk("t4_b_ack_out", b_if.ack_out, 0);
        chk("t4_a_cords_out", a_if.cords_out, 0);
        chk("t4_b_rx_cords", b_if.rx_cords, 0);
        chk("t4_a_result_hit", a_if.result_hit, 0);
        chk("t4_a_shot_ready", a_if.shot_ready, 1);
        chk("t4_a_result_valid", a_if.result_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a_res_q.delete();
        fire(0, 8'h5A, 0);
        wait_rx(1);
        answer(1, 1'b0, 1);
        wait_res(0);
        wait_idle();
        chk("t4_b_rx_cords_after", b_if.rx_cords, 8'h5A);
        chk("t4_a_result_hit_after", a_if.result_hit, 0);

        // shot_valid held through REQ, stray answers while RX idle
        a_ack_seen = 1'b0;
        fire(0, 8'h12, 1);
        a_if.shot_cords = 8'hEE;
        a_if.answer_valid = 1'b1; a_if.answer_hit = 1'b1;
        b_if.answer_valid = 1'b1; b_if.answer_hit = 1'b0;
        @(posedge clk);
        #1;
        a_if.answer_valid = 1'b0;
        b_if.answer_valid = 1'b0;
        wait_rx(1);
        answer(1, 1'b1, 1);
        wait_res(0);
        a_if.shot_valid = 1'b0;
        wait_idle();
        chk("t5_b_rx_cords", b_if.rx_cords, 8'h12);
        chk("t5_a_no_ack_out", a_ack_seen, 0);
        chk("t5_a_result_hit", a_if.result_hit, 1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/warships_link.md
WARSHIPS_LINK -- requirements
Module: warships_link

Interface
REQ-001 Parameter X_ADDR_WIDTH, 4, column-coordinate width in bits.
REQ-002 Parameter Y_ADDR_WIDTH, 4, row-coordinate width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, 1000000, maximum clk cycles TX waits for peer ack.
REQ-004 Let CW = X_ADDR_WIDTH+Y_ADDR_WIDTH; coordinate format {x,y}, x in MSBs.
REQ-005 One clock; reset is asynchronous and active-high; ports clk and rst.
REQ-006 clk  in  1  system clock (control clock domain).
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 shot_valid  in  1  local request to fire at shot_cords; accepted only when shot_ready=1.
REQ-009 shot_cords  in  CW  local target coordinate.
REQ-010 shot_ready  out  1  TX idle, able to accept a shot.
REQ-011 result_valid  out  1  one-cycle pulse, peer answer captured.
REQ-012 result_hit  out  1  peer answer (1=hit), held until next result_valid.
REQ-013 result_timeout  out  1  one-cycle pulse, TX attempt abandoned.
REQ-014 rx_valid  out  1  one-cycle pulse, peer shot received.
REQ-015 rx_cords  out  CW  received coordinate, held until next rx_valid.
REQ-016 answer_valid  in  1  local answer to pending received shot.
REQ-017 answer_hit  in  1  local answer value.
REQ-018 req_out / cords_out / ack_in / hit_in  out/out/in/in  1/CW/1/1  TX link to peer.
REQ-019 req_in / cords_in / ack_out / hit_out  in/in/out/out  1/CW/1/1  RX link from peer.

Function
REQ-020 req_in and ack_in SHALL pass two-flop synchronisers before use; cords_in and hit_in SHALL be sampled only while synced strobe is 1 (4-phase, data stable).
REQ-021 TX FSM states IDLE, REQ, DROP; shot_ready=1 only in IDLE.
REQ-022 IDLE: shot_valid=1 -> register shot_cords to cords_out, req_out=1 next cycle, go REQ.
REQ-023 REQ: ack_sync=1 -> result_hit<=hit_in, result_valid pulse, req_out=0, go DROP.
REQ-024 DROP: ack_sync=0 -> IDLE; cords_out held throughout.
REQ-025 RX FSM states IDLE, WAIT_ANS, ACK.
REQ-026 IDLE: req_sync=1 -> rx_cords<=cords_in, rx_valid pulse, go WAIT_ANS.
REQ-027 WAIT_ANS: answer_valid=1 -> hit_out<=answer_hit, ack_out=1 next cycle, go ACK; hit_out held until next answer.
REQ-028 ACK: req_sync=0 -> ack_out=0, go IDLE.
REQ-029 answer_valid outside WAIT_ANS SHALL be ignored; shot_valid outside TX IDLE SHALL be ignored.
REQ-030 TX and RX SHALL operate independently; simultaneous outgoing and incoming shots both complete.
REQ-031 Latency: shot_valid accept -> req_out=1 is 1 cycle; ack_in edge -> result_valid is 3 cycles (2 sync + 1 register).

Reset
REQ-032 On rst: both FSMs IDLE; req_out, ack_out, hit_out, result_valid, result_hit, result_timeout, rx_valid = 0; cords_out, rx_cords = 0; synchronisers and timeout counter = 0; shot_ready=1 after release.
REQ-033 Reset mid-handshake SHALL drop req_out/ack_out immediately (async); no result or rx pulse is produced for the aborted transfer.

Configuration
REQ-034 Macro LINK_TIMEOUT_EN defined: counter runs in REQ, clears on entry; on reaching TIMEOUT_CYCLES-1 without ack_sync, req_out=0, result_timeout pulse, result_hit unchanged, go DROP (waits ack_sync=0 before IDLE).
REQ-035 LINK_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; result_timeout tied 0; TIMEOUT_CYCLES unused.

Verification
REQ-036 Loopback two instances, A shot_valid with {x=3,y=7}=8'h37 -> B rx_valid once with rx_cords=8'h37.
REQ-037 B answer_valid, answer_hit=1 -> A result_valid once, result_hit=1; both req/ack return to 0; A shot_ready=1.
REQ-038 Both sides fire simultaneously (8'h00 and 8'hBB) -> both rx_valid with swapped coords, both results after answers, no deadlock.
REQ-039 LINK_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack_in held 0 -> result_timeout pulses 16 cycles after req_out rises, req_out=0, no result_valid.
REQ-040 Assert rst while A in REQ and B in WAIT_ANS -> all outputs at reset values same cycle; fresh 8'h5A shot afterwards completes normally.
REQ-041 shot_valid held high during REQ, answer_valid pulsed while RX IDLE -> no second transfer, no ack_out.
